// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op/state encodings for the HI/LO multiply-divide unit
package mips_pkg;
   localparam int ITER_COUNT = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2
   } state_e;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction
endpackage

// File: rtl/mips_muldiv_ctrl_if.sv
// rtl/mips_muldiv_ctrl_if.sv - issue/result bundle between decode and the HI/LO unit
interface mips_muldiv_ctrl_if;
   import mips_pkg::*;

   logic        start;
   op_e         op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        rd_hilo;
   logic        ready;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, src_a, src_b, rd_hilo,
      input  ready, stall, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, rd_hilo,
      output ready, stall, done, hi, lo
   );
endinterface

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one-bit-per-cycle unsigned shift-add multiply / restoring divide
module mips_muldiv_step (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        run_i,
   input  logic        is_div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] acc_o
);
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d;
   logic [32:0] sum;
   logic [64:0] shifted;
   logic [32:0] diff;

   // multiply: acc = {partial product, remaining multiplier bits}
   // divide:   acc = {partial remainder, dividend bits / quotient bits}
   always_comb begin
      acc_d   = acc_q;
      b_d     = b_q;
      sum     = {1'b0, acc_q[63:32]} + {1'b0, b_q};
      shifted = {acc_q, 1'b0};
      diff    = shifted[64:32] - {1'b0, b_q};
      if (load_i) begin
         acc_d = {32'd0, a_i};
         b_d   = b_i;
      end else if (run_i) begin
         if (is_div_i) begin
            if (shifted[64:32] >= {1'b0, b_q})
               acc_d = {diff[31:0], shifted[31:1], 1'b1};
            else
               acc_d = shifted[63:0];
         end else begin
            acc_d = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
      end
   end

   assign acc_o = acc_q;
endmodule

// File: rtl/mips_muldiv_ctrl.sv
// rtl/mips_muldiv_ctrl.sv - HI/LO owner: issue FSM, sign handling and result write-back
module mips_muldiv_ctrl
   import mips_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   mips_muldiv_ctrl_if.slave   bus
);
   state_e      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;
   logic        neg_rem_q, neg_rem_d;
   logic        load, run, signed_op, zero_div, op_div;
   logic [31:0] a_op, b_op, quo, rem;
   logic [63:0] acc, prod;

   mips_muldiv_step u_step (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load),
      .run_i    (run),
      .is_div_i (is_div_q),
      .a_i      (a_op),
      .b_i      (b_op),
      .acc_o    (acc)
   );

   assign prod = neg_q ? (64'd0 - acc) : acc;
   assign quo  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
   assign rem  = neg_rem_q ? (32'd0 - acc[63:32]) : acc[63:32];

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      load      = 1'b0;
      run       = 1'b0;
      op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
      zero_div  = op_div && (bus.src_b == 32'd0);
      // a zero divisor runs unsigned on raw operands so hi comes back as src_a
      signed_op = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && !zero_div;
      a_op      = signed_op ? abs32(bus.src_a) : bus.src_a;
      b_op      = signed_op ? abs32(bus.src_b) : bus.src_b;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_MTHI: hi_d = bus.src_a;
                  OP_MTLO: lo_d = bus.src_a;
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     load      = 1'b1;
                     is_div_d  = op_div;
                     neg_d     = signed_op && (bus.src_a[31] ^ bus.src_b[31]);
                     neg_rem_d = signed_op && bus.src_a[31];
                     count_d   = 5'(ITER_COUNT - 1);
                     state_d   = RUN;
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            run = 1'b1;
            if (count_q == 5'd0)
               state_d = FIXUP;
            else
               count_d = count_q - 5'd1;
         end
         FIXUP: begin
            hi_d    = is_div_q ? rem : prod[63:32];
            lo_d    = is_div_q ? quo : prod[31:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.stall = bus.rd_hilo && !bus.ready;
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// tb/tb_mips_muldiv_ctrl.sv - directed vectors and corner sequences for mips_muldiv_ctrl
module tb_mips_muldiv_ctrl;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_muldiv_ctrl_if bus ();

   mips_muldiv_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      op_e         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // on return n is the cycle index (T+n) where done was seen, 41 on timeout
   task automatic wait_done(output int n, output bit rdy_low_ok);
      n = 1;
      rdy_low_ok = 1'b1;
      while (!bus.done && n <= 40) begin
         if (bus.ready) rdy_low_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      bit rl;
      int cyc;
      int pulses;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4] = '{OP_DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFFFFFF};
      vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.op      = OP_MULT;
      bus.src_a   = '0;
      bus.src_b   = '0;
      bus.rd_hilo = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bus.rd_hilo = 1'b1;
      #1;
      check("reset_ready", 32'(bus.ready), 32'd1);
      check("reset_hi", bus.hi, 32'd0);
      check("reset_lo", bus.lo, 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("idle_stall", 32'(bus.stall), 32'd0);
      bus.rd_hilo = 1'b0;

      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(n, rl);
         check($sformatf("vec%0d_latency", i), 32'(n), 32'd34);
         check($sformatf("vec%0d_ready_low", i), 32'(rl), 32'd1);
         check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
      end

      issue(OP_MTHI, 32'h00001234, 32'd0);
      check("mthi_hi", bus.hi, 32'h00001234);
      check("mthi_done", 32'(bus.done), 32'd0);
      issue(OP_MTLO, 32'h000000A5, 32'd0);
      check("mtlo_lo", bus.lo, 32'h000000A5);
      check("mtlo_done", 32'(bus.done), 32'd0);
      check("mtlo_ready", 32'(bus.ready), 32'd1);

      // stall while running, ignored second start, old HI stays visible
      issue(OP_MULT, 32'd7, 32'd6);
      cyc = 1;
      while (!bus.done && cyc <= 40) begin
         if (cyc == 5) begin
            bus.rd_hilo = 1'b1;
            #1;
            check("run_stall", 32'(bus.stall), 32'd1);
            check("run_old_hi", bus.hi, 32'h00001234);
            bus.rd_hilo = 1'b0;
         end
         if (cyc == 10) begin
            bus.start = 1'b1;
            bus.op    = OP_MTHI;
            bus.src_a = 32'hDEAD0000;
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         cyc++;
      end
      check("ignored_start_latency", 32'(cyc), 32'd34);
      check("ignored_start_hi", bus.hi, 32'd0);
      check("ignored_start_lo", bus.lo, 32'd42);

      // start accepted in the done cycle
      issue(OP_MULTU, 32'd2, 32'd3);
      wait_done(n, rl);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.src_a = 32'd100;
      bus.src_b = 32'd7;
      check("b2b_done", 32'(bus.done), 32'd1);
      check("b2b_first_lo", bus.lo, 32'd6);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b_accepted", 32'(bus.ready), 32'd0);
      wait_done(n, rl);
      check("b2b_latency", 32'(n), 32'd34);
      check("b2b_lo", bus.lo, 32'd14);
      check("b2b_hi", bus.hi, 32'd2);

      // reset mid-run aborts without a write
      issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_ready", 32'(bus.ready), 32'd1);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) pulses++;
         @(posedge clk);
         #1;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      check("abort_lo_after", bus.lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mips_muldiv_ctrl.md
MIPS_MULDIV_CTRL -- requirements
Module: mips_muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: issue request, sampled only at clk rising edge.
REQ-004 SHALL have port op, input, 3 bits: MULT, MULTU, DIV, DIVU, MTHI, MTLO (enum from shared package).
REQ-005 SHALL have port src_a, input, 32 bits: rs operand, the multiplicand/dividend, or the MTHI/MTLO data.
REQ-006 SHALL have port src_b, input, 32 bits: rt operand, the multiplier/divisor.
REQ-007 SHALL have port rd_hilo, input, 1 bit: decode stage is executing MFHI/MFLO this cycle.
REQ-008 SHALL have port ready, output, 1 bit: controller idle, start will be accepted.
REQ-009 SHALL have port stall, output, 1 bit: combinational rd_hilo && !ready.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, new HI/LO visible this cycle.
REQ-011 SHALL have ports hi and lo, outputs, 32 bits each: architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIXUP; ready = (state == IDLE).
REQ-013 SHALL accept start only in IDLE; start while not ready is ignored, with no state change.
REQ-014 SHALL handle MTHI/MTLO accepted at edge T: hi (or lo) = src_a after edge T; state stays IDLE; done stays 0.
REQ-015 SHALL handle MULT/DIV-family accepted at edge T: latch |operands| (signed ops) or raw operands, latch sign flags, load count = 31, enter RUN.
REQ-016 SHALL in RUN iterate one bit per cycle for exactly 32 cycles: shift-add for multiply, restoring shift-subtract for divide; then enter FIXUP.
REQ-017 SHALL in FIXUP: negate 64-bit product if sign(a) != sign(b); negate quotient if signs differ; give the remainder the sign of the dividend; write hi/lo at the FIXUP-exit edge; return to IDLE.
REQ-018 SHALL register done: assert it for exactly the first IDLE cycle after FIXUP; hi/lo hold the new result in that cycle.
REQ-019 SHALL give a fixed latency: start edge T to done cycle = T+34 cycles; ready low for cycles T+1..T+33.
REQ-020 SHALL keep hi/lo unchanged during RUN/FIXUP, so old values remain visible, while stall blocks reads.
REQ-021 SHALL handle divide by zero, signed or unsigned: complete with normal latency, lo = 32'hFFFFFFFF, hi = src_a, no sign fixup.
REQ-022 SHALL handle DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0, no exception.
REQ-023 SHALL use an unsigned intermediate: 64-bit accumulator; divisor compare on 33 bits; abs(32'h80000000) = 32'h80000000.
REQ-024 SHALL permit start in the done cycle: it is accepted, done still pulses, and the new op begins.

Reset
REQ-025 SHALL on reset = 1 at any edge, including mid-RUN/FIXUP: state = IDLE, hi = 0, lo = 0, done = 0, count = 0, and abort the in-flight op without a hi/lo write.
REQ-026 SHALL give reset priority over start in the same cycle; ready = 1 in the cycle after reset.

Structure
REQ-027 SHALL place the op enum, state enum and ITER_COUNT = 32 in the shared package mips_pkg.
REQ-028 SHALL place the iteration datapath (accumulator, shift/add/subtract step) in one sub-module, mips_muldiv_step; FSM, sign handling and HI/LO stay in mips_muldiv_ctrl.
REQ-029 SHALL replace the ALU's HILO path; the ALU forwards mfhi/mflo from hi/lo outputs.

Verification
REQ-030 SHALL cover MULT: src_a = 32'hFFFFFFFD, src_b = 5 -> done at T+34, hi = 32'hFFFFFFFF, lo = 32'hFFFFFFF1.
REQ-031 SHALL cover MULTU: src_a = src_b = 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001.
REQ-032 SHALL cover DIV and DIVU: DIV -7/2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF; DIVU 100/7 -> lo = 14, hi = 2.
REQ-033 SHALL cover DIVU 9/0 -> lo = 32'hFFFFFFFF, hi = 9; and DIV 32'h80000000 / -1 -> lo = 32'h80000000, hi = 0.
REQ-034 SHALL cover rd_hilo = 1 at T+5 -> stall = 1; second start at T+10 ignored; MTLO 32'hA5 in IDLE -> lo = 32'hA5 next cycle, done = 0.
REQ-035 SHALL cover reset at T+12 of a MULT -> next cycle ready = 1, hi = lo = 0, done never pulses.
